counter_nb_mod: RTL and testbench

- Parametrised successor of the team's 4-bit multi-mode counter: WIDTH-bit, modulo-(MAX+1) counter with four modes (up 1, down 1, down STEP, load D).
- Adds a cascade input CI and a combinational terminal-count output TC, so several instances chain into wider counters.
- Adds a hold state on ENABLE low and a registered ZERO flag.
- Sits in the counter/test-generator section of the datapath.

---
 rtl/counter_nb_mod.sv | 156 +++++++++++++++
 tb/tb_counter_nb_mod.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_nb_mod.sv
//============================================================================
// Module   : counter_nb_mod
// Desc     : WIDTH-bit modulo-(MAX+1) counter (down STEP / down 1 / up 1 /
//            load D) with cascade input CI, terminal count TC, ZERO flag.
// Options  : COUNTER_NB_SATURATE_EN - saturate at boundaries instead of wrap
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module counter_nb_mod #(
  parameter int WIDTH = 4,
  parameter int STEP  = 3,
  parameter int MAX   = (2**WIDTH)-1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CI,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             LOAD,
  output logic             TC,
  output logic             ZERO
);

  localparam logic [1:0] c_MODE_DN_STEP = 2'b00;
  localparam logic [1:0] c_MODE_DN_ONE  = 2'b01;
  localparam logic [1:0] c_MODE_UP      = 2'b10;
  localparam logic [1:0] c_MODE_LOAD    = 2'b11;

  // All arithmetic runs one bit wider than the count so nothing truncates.
  localparam logic [WIDTH:0] c_MAX_X  = MAX[WIDTH:0];
  localparam logic [WIDTH:0] c_STEP_X = STEP[WIDTH:0];
  localparam logic [WIDTH:0] c_ONE_X  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] c_ZERO_X = '0;

  logic [WIDTH-1:0] r_q;
  logic             r_rco;
  logic             r_load;
  logic             r_zero;

  logic [WIDTH:0]   w_q_x;
  logic [WIDTH:0]   w_d_x;
  logic [WIDTH:0]   w_load_x;
  logic             w_up_wrap;
  logic             w_dn1_wrap;
  logic             w_dns_wrap;
  logic [WIDTH:0]   w_up_wrap_x;
  logic [WIDTH:0]   w_dn1_wrap_x;
  logic [WIDTH:0]   w_dns_wrap_x;
  logic [WIDTH:0]   w_step_x;
  logic             w_step_wrap;
  logic [WIDTH:0]   w_q_nxt_x;
  logic             w_rco_nxt;
  logic             w_load_nxt;
  logic             w_zero_nxt;
  logic             w_boundary;

  assign w_q_x    = {1'b0, r_q};
  assign w_d_x    = {1'b0, D};
  assign w_load_x = (w_d_x > c_MAX_X) ? c_MAX_X : w_d_x;

  // Up treats an out-of-range Q as a wrap so a bad state self-recovers.
  assign w_up_wrap  = (w_q_x >= c_MAX_X);
  assign w_dn1_wrap = (w_q_x == c_ZERO_X);
  assign w_dns_wrap = (w_q_x < c_STEP_X);

`ifdef COUNTER_NB_SATURATE_EN
  assign w_up_wrap_x  = c_MAX_X;
  assign w_dn1_wrap_x = c_ZERO_X;
  assign w_dns_wrap_x = c_ZERO_X;
`else
  localparam logic [WIDTH:0] c_MOD_X = c_MAX_X + c_ONE_X;

  assign w_up_wrap_x  = c_ZERO_X;
  assign w_dn1_wrap_x = c_MAX_X;
  assign w_dns_wrap_x = w_q_x + c_MOD_X - c_STEP_X;
`endif

  always_comb begin
    w_step_x    = w_q_x;
    w_step_wrap = 1'b0;
    case (MODO)
      c_MODE_UP: begin
        w_step_wrap = w_up_wrap;
        w_step_x    = w_up_wrap ? w_up_wrap_x : (w_q_x + c_ONE_X);
      end
      c_MODE_DN_ONE: begin
        w_step_wrap = w_dn1_wrap;
        w_step_x    = w_dn1_wrap ? w_dn1_wrap_x : (w_q_x - c_ONE_X);
      end
      c_MODE_DN_STEP: begin
        w_step_wrap = w_dns_wrap;
        w_step_x    = w_dns_wrap ? w_dns_wrap_x : (w_q_x - c_STEP_X);
      end
      c_MODE_LOAD: begin
        w_step_wrap = 1'b0;
        w_step_x    = w_q_x;
      end
    endcase
  end

  // Load ignores CI; counting needs both ENABLE and CI.
  always_comb begin
    w_q_nxt_x  = w_q_x;
    w_rco_nxt  = 1'b0;
    w_load_nxt = 1'b0;
    if (ENABLE) begin
      if (MODO == c_MODE_LOAD) begin
        w_q_nxt_x  = w_load_x;
        w_load_nxt = 1'b1;
      end else if (CI) begin
        w_q_nxt_x = w_step_x;
        w_rco_nxt = w_step_wrap;
      end
    end
  end

  assign w_zero_nxt = (w_q_nxt_x == c_ZERO_X);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_q    <= '0;
      r_rco  <= 1'b0;
      r_load <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_q    <= w_q_nxt_x[WIDTH-1:0];
      r_rco  <= w_rco_nxt;
      r_load <= w_load_nxt;
      r_zero <= w_zero_nxt;
    end
  end

  // TC anticipates the wrapping edge so the next stage steps on that edge.
  always_comb begin
    w_boundary = 1'b0;
    case (MODO)
      c_MODE_UP:      w_boundary = (w_q_x == c_MAX_X);
      c_MODE_DN_ONE:  w_boundary = (w_q_x == c_ZERO_X);
      c_MODE_DN_STEP: w_boundary = (w_q_x < c_STEP_X);
      c_MODE_LOAD:    w_boundary = 1'b0;
    endcase
  end

  assign TC   = ENABLE & CI & w_boundary;
  assign Q    = r_q;
  assign RCO  = r_rco;
  assign LOAD = r_load;
  assign ZERO = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_counter_nb_mod.sv
// Self-checking bench for counter_nb_mod: directed scenarios, a two-stage
// cascade, and randomized traffic against a modular-arithmetic model.
`default_nettype none

module tb_counter_nb_mod;

  localparam int STEPV = 3;
  localparam int MAXA  = 15;
  localparam int MAXB  = 9;
`ifdef COUNTER_NB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic a_en = 1'b0, a_ci = 1'b0;
  logic [1:0] a_modo = 2'b00;
  logic [3:0] a_d = 4'd0;
  logic [3:0] a_q;
  logic a_rco, a_load, a_tc, a_zero;

  logic b_en = 1'b0, b_ci = 1'b0;
  logic [1:0] b_modo = 2'b00;
  logic [3:0] b_d = 4'd0;
  logic [3:0] b_q;
  logic b_rco, b_load, b_tc, b_zero;

  logic c_en = 1'b0, c_ci = 1'b0;
  logic [1:0] c_modo = 2'b00;
  logic [3:0] c_d = 4'd0;
  logic [3:0] lo_q, hi_q;
  logic lo_rco, lo_load, lo_tc, lo_zero;
  logic hi_rco, hi_load, hi_tc, hi_zero;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  counter_nb_mod #(.WIDTH(4), .STEP(STEPV), .MAX(MAXA)) u_dut_a (
    .CLK(clk), .RESET(rst_n), .ENABLE(a_en), .CI(a_ci), .MODO(a_modo), .D(a_d),
    .Q(a_q), .RCO(a_rco), .LOAD(a_load), .TC(a_tc), .ZERO(a_zero));

  counter_nb_mod #(.WIDTH(4), .STEP(STEPV), .MAX(MAXB)) u_dut_b (
    .CLK(clk), .RESET(rst_n), .ENABLE(b_en), .CI(b_ci), .MODO(b_modo), .D(b_d),
    .Q(b_q), .RCO(b_rco), .LOAD(b_load), .TC(b_tc), .ZERO(b_zero));

  counter_nb_mod #(.WIDTH(4), .STEP(STEPV), .MAX(MAXA)) u_lo (
    .CLK(clk), .RESET(rst_n), .ENABLE(c_en), .CI(c_ci), .MODO(c_modo), .D(c_d),
    .Q(lo_q), .RCO(lo_rco), .LOAD(lo_load), .TC(lo_tc), .ZERO(lo_zero));

  counter_nb_mod #(.WIDTH(4), .STEP(STEPV), .MAX(MAXA)) u_hi (
    .CLK(clk), .RESET(rst_n), .ENABLE(c_en), .CI(lo_tc), .MODO(c_modo), .D(c_d),
    .Q(hi_q), .RCO(hi_rco), .LOAD(hi_load), .TC(hi_tc), .ZERO(hi_zero));

  // Signed displacement a counting edge would apply in each mode.
  function automatic int ref_delta(input logic [1:0] modo, input int stepv);
    case (modo)
      2'b10:   return 1;
      2'b01:   return -1;
      2'b00:   return -stepv;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_tc(input int maxv, input int stepv, input int q,
                                input bit en, input bit ci, input logic [1:0] modo);
    int raw;
    raw = q + ref_delta(modo, stepv);
    return en && ci && (modo != 2'b11) && (raw < 0 || raw > maxv);
  endfunction

  function automatic void ref_edge(input int maxv, input int stepv, input int q,
                                   input bit en, input bit ci, input logic [1:0] modo,
                                   input int d, output int qn, output bit rco,
                                   output bit load);
    int raw;
    qn = q; rco = 1'b0; load = 1'b0;
    if (!en) return;
    if (modo == 2'b11) begin
      qn = (d > maxv) ? maxv : d;
      load = 1'b1;
    end else if (ci) begin
      raw = q + ref_delta(modo, stepv);
      if (raw < 0 || raw > maxv) begin
        rco = 1'b1;
        if (SAT) qn = (raw < 0) ? 0 : maxv;
        else     qn = ((raw % (maxv + 1)) + maxv + 1) % (maxv + 1);
      end else begin
        qn = raw;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #10;
    vectors++; if (a_q !== 4'd0) begin miscompares++; $display("FAIL reset_q: got %0d expected 0", a_q); end
    vectors++; if (a_zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero: got %b expected 1", a_zero); end
    vectors++; if (a_rco !== 1'b0) begin miscompares++; $display("FAIL reset_rco: got %b expected 0", a_rco); end
    vectors++; if (a_load !== 1'b0) begin miscompares++; $display("FAIL reset_load: got %b expected 0", a_load); end
    @(posedge clk); #1 rst_n = 1'b1;
    a_en = 1'b1; a_ci = 1'b1; a_modo = 2'b11; a_d = 4'd6;
    tick();
    a_modo = 2'b10;
    tick();
    vectors++; if (a_q !== 4'd7) begin miscompares++; $display("FAIL midcount_q: got %0d expected 7", a_q); end
    #3 rst_n = 1'b0;
    #1;
    vectors++; if (a_q !== 4'd0) begin miscompares++; $display("FAIL async_reset_q: got %0d expected 0", a_q); end
    vectors++; if (a_zero !== 1'b1) begin miscompares++; $display("FAIL async_reset_zero: got %b expected 1", a_zero); end
    vectors++; if (a_rco !== 1'b0) begin miscompares++; $display("FAIL async_reset_rco: got %b expected 0", a_rco); end
    #2 rst_n = 1'b1;
    tick();
    vectors++; if (a_q !== 4'd1) begin miscompares++; $display("FAIL first_edge_q: got %0d expected 1", a_q); end
    vectors++; if (a_zero !== 1'b0) begin miscompares++; $display("FAIL first_edge_zero: got %b expected 0", a_zero); end
  endtask

  task automatic test_up_wrap();
    a_en = 1'b1; a_ci = 1'b1; a_modo = 2'b11; a_d = 4'd14;
    tick();
    a_modo = 2'b10;
    tick();
    vectors++; if (a_q !== 4'd15) begin miscompares++; $display("FAIL up_q15: got %0d expected 15", a_q); end
    vectors++; if (a_rco !== 1'b0) begin miscompares++; $display("FAIL up_rco0: got %b expected 0", a_rco); end
    vectors++; if (a_tc !== 1'b1) begin miscompares++; $display("FAIL up_tc: got %b expected 1", a_tc); end
    tick();
    vectors++; if (a_q !== (SAT ? 4'd15 : 4'd0)) begin miscompares++; $display("FAIL up_wrap_q: got %0d expected %0d", a_q, SAT ? 15 : 0); end
    vectors++; if (a_rco !== 1'b1) begin miscompares++; $display("FAIL up_wrap_rco: got %b expected 1", a_rco); end
    vectors++; if (a_zero !== !SAT) begin miscompares++; $display("FAIL up_wrap_zero: got %b expected %b", a_zero, !SAT); end
    a_en = 1'b0;
    #1;
    vectors++; if (a_tc !== 1'b0) begin miscompares++; $display("FAIL hold_tc: got %b expected 0", a_tc); end
    tick();
    vectors++; if (a_q !== (SAT ? 4'd15 : 4'd0)) begin miscompares++; $display("FAIL hold_q: got %0d expected %0d", a_q, SAT ? 15 : 0); end
    vectors++; if (a_rco !== 1'b0) begin miscompares++; $display("FAIL hold_rco: got %b expected 0", a_rco); end
  endtask

  task automatic test_down_step();
    a_en = 1'b1; a_ci = 1'b1; a_modo = 2'b11; a_d = 4'd4;
    tick();
    a_modo = 2'b00;
    tick();
    vectors++; if (a_q !== 4'd1) begin miscompares++; $display("FAIL dstep_q1: got %0d expected 1", a_q); end
    vectors++; if (a_rco !== 1'b0) begin miscompares++; $display("FAIL dstep_rco0: got %b expected 0", a_rco); end
    vectors++; if (a_tc !== 1'b1) begin miscompares++; $display("FAIL dstep_tc: got %b expected 1", a_tc); end
    tick();
    vectors++; if (a_q !== (SAT ? 4'd0 : 4'd14)) begin miscompares++; $display("FAIL dstep_wrap_q: got %0d expected %0d", a_q, SAT ? 0 : 14); end
    vectors++; if (a_rco !== 1'b1) begin miscompares++; $display("FAIL dstep_wrap_rco: got %b expected 1", a_rco); end
    vectors++; if (a_zero !== SAT) begin miscompares++; $display("FAIL dstep_wrap_zero: got %b expected %b", a_zero, SAT); end
  endtask

  task automatic test_stall_load();
    a_en = 1'b1; a_ci = 1'b0; a_modo = 2'b10;
    #1;
    vectors++; if (a_tc !== 1'b0) begin miscompares++; $display("FAIL stall_tc: got %b expected 0", a_tc); end
    tick();
    vectors++; if (a_q !== (SAT ? 4'd0 : 4'd14)) begin miscompares++; $display("FAIL stall_q: got %0d expected %0d", a_q, SAT ? 0 : 14); end
    vectors++; if (a_rco !== 1'b0) begin miscompares++; $display("FAIL stall_rco: got %b expected 0", a_rco); end
    a_modo = 2'b11; a_d = 4'd5;
    tick();
    vectors++; if (a_q !== 4'd5) begin miscompares++; $display("FAIL load_ci0_q: got %0d expected 5", a_q); end
    vectors++; if (a_load !== 1'b1) begin miscompares++; $display("FAIL load_ci0_load: got %b expected 1", a_load); end
    a_d = 4'd3;
    tick();
    vectors++; if (a_q !== 4'd3) begin miscompares++; $display("FAIL load_b2b_q: got %0d expected 3", a_q); end
    vectors++; if (a_load !== 1'b1) begin miscompares++; $display("FAIL load_b2b_load: got %b expected 1", a_load); end
    a_modo = 2'b10; a_ci = 1'b1;
    tick();
    vectors++; if (a_q !== 4'd4) begin miscompares++; $display("FAIL after_load_q: got %0d expected 4", a_q); end
    vectors++; if (a_load !== 1'b0) begin miscompares++; $display("FAIL after_load_load: got %b expected 0", a_load); end
  endtask

  task automatic test_max9();
    b_en = 1'b1; b_ci = 1'b1; b_modo = 2'b11; b_d = 4'd12;
    tick();
    vectors++; if (b_q !== 4'd9) begin miscompares++; $display("FAIL m9_clamp_q: got %0d expected 9", b_q); end
    vectors++; if (b_load !== 1'b1) begin miscompares++; $display("FAIL m9_clamp_load: got %b expected 1", b_load); end
    b_modo = 2'b10;
    tick();
    vectors++; if (b_q !== (SAT ? 4'd9 : 4'd0)) begin miscompares++; $display("FAIL m9_up_q: got %0d expected %0d", b_q, SAT ? 9 : 0); end
    vectors++; if (b_rco !== 1'b1) begin miscompares++; $display("FAIL m9_up_rco: got %b expected 1", b_rco); end
    vectors++; if (b_load !== 1'b0) begin miscompares++; $display("FAIL m9_up_load: got %b expected 0", b_load); end
    b_modo = 2'b11; b_d = 4'd0;
    tick();
    b_modo = 2'b01;
    tick();
    vectors++; if (b_q !== (SAT ? 4'd0 : 4'd9)) begin miscompares++; $display("FAIL m9_dn_q: got %0d expected %0d", b_q, SAT ? 0 : 9); end
    vectors++; if (b_rco !== 1'b1) begin miscompares++; $display("FAIL m9_dn_rco: got %b expected 1", b_rco); end
    b_en = 1'b0;
  endtask

  task automatic test_cascade();
    int exp_lo, exp_hi;
    bit exp_rco;
    c_en = 1'b1; c_ci = 1'b1; c_modo = 2'b11; c_d = 4'd0;
    tick();
    c_modo = 2'b10;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (SAT) begin
        exp_lo = (k > 15) ? 15 : k;
        exp_hi = (k >= 16) ? k - 15 : 0;
        exp_rco = (k >= 16);
      end else begin
        exp_lo = k % 16;
        exp_hi = k / 16;
        exp_rco = (k == 16);
      end
      vectors++; if (lo_q !== 4'(exp_lo)) begin miscompares++; $display("FAIL casc_lo edge %0d: got %0d expected %0d", k, lo_q, exp_lo); end
      vectors++; if (hi_q !== 4'(exp_hi)) begin miscompares++; $display("FAIL casc_hi edge %0d: got %0d expected %0d", k, hi_q, exp_hi); end
      vectors++; if (lo_rco !== exp_rco) begin miscompares++; $display("FAIL casc_rco edge %0d: got %b expected %b", k, lo_rco, exp_rco); end
    end
    c_en = 1'b0;
  endtask

  task automatic test_random();
    int qa, qb, qan, qbn;
    bit rca, rcb, lda, ldb, tca, tcb;
    @(posedge clk); #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    qa = 0; qb = 0;
    for (int n = 0; n < 400; n++) begin
      a_en = ($urandom_range(0, 7) != 0); a_ci = ($urandom_range(0, 3) != 0);
      a_modo = 2'($urandom_range(0, 3)); a_d = 4'($urandom_range(0, 15));
      b_en = ($urandom_range(0, 7) != 0); b_ci = ($urandom_range(0, 3) != 0);
      b_modo = 2'($urandom_range(0, 3)); b_d = 4'($urandom_range(0, 15));
      #1;
      tca = ref_tc(MAXA, STEPV, qa, a_en, a_ci, a_modo);
      tcb = ref_tc(MAXB, STEPV, qb, b_en, b_ci, b_modo);
      vectors++; if (a_tc !== tca) begin miscompares++; $display("FAIL rnd_a_tc cyc %0d: got %b expected %b", n, a_tc, tca); end
      vectors++; if (b_tc !== tcb) begin miscompares++; $display("FAIL rnd_b_tc cyc %0d: got %b expected %b", n, b_tc, tcb); end
      ref_edge(MAXA, STEPV, qa, a_en, a_ci, a_modo, int'(a_d), qan, rca, lda);
      ref_edge(MAXB, STEPV, qb, b_en, b_ci, b_modo, int'(b_d), qbn, rcb, ldb);
      qa = qan; qb = qbn;
      tick();
      vectors++; if (a_q !== 4'(qa)) begin miscompares++; $display("FAIL rnd_a_q cyc %0d: got %0d expected %0d", n, a_q, qa); end
      vectors++; if (a_rco !== rca) begin miscompares++; $display("FAIL rnd_a_rco cyc %0d: got %b expected %b", n, a_rco, rca); end
      vectors++; if (a_load !== lda) begin miscompares++; $display("FAIL rnd_a_load cyc %0d: got %b expected %b", n, a_load, lda); end
      vectors++; if (a_zero !== (qa == 0)) begin miscompares++; $display("FAIL rnd_a_zero cyc %0d: got %b expected %b", n, a_zero, qa == 0); end
      vectors++; if (b_q !== 4'(qb)) begin miscompares++; $display("FAIL rnd_b_q cyc %0d: got %0d expected %0d", n, b_q, qb); end
      vectors++; if (b_rco !== rcb) begin miscompares++; $display("FAIL rnd_b_rco cyc %0d: got %b expected %b", n, b_rco, rcb); end
      vectors++; if (b_load !== ldb) begin miscompares++; $display("FAIL rnd_b_load cyc %0d: got %b expected %b", n, b_load, ldb); end
      vectors++; if (b_zero !== (qb == 0)) begin miscompares++; $display("FAIL rnd_b_zero cyc %0d: got %b expected %b", n, b_zero, qb == 0); end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_step();
    test_stall_load();
    test_max9();
    test_cascade();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
